// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-unit bus bundle: instruction-memory request/response side plus the
// decoded-instruction handoff (with jump/branch redirect info) to downstream.
interface pc_fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        jump_en;
    logic [25:0] jump_offset;
    logic        branch_en;
    logic [15:0] branch_imm;

    // The fetch controller is the master.
    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  instr_ready, jump_en, jump_offset, branch_en, branch_imm
    );

    // Memory and downstream consumer side.
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_gnt, imem_rvalid, imem_rdata,
        output instr_ready, jump_en, jump_offset, branch_en, branch_imm
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Single-outstanding instruction fetch controller: requests one word at a time,
// holds it until consumed, then redirects the PC for jumps/branches.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    pc_fetch_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        FULL
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        req_q;
    logic [31:0] addr_q;
    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;

    logic [31:0] seq_pc;
    logic [31:0] next_pc;

    // Redirect target for the held instruction; jump takes priority over branch.
    always_comb begin
        seq_pc = instr_pc_q + 32'd1;
        if (bus.jump_en) begin
            next_pc = {seq_pc[31:26], bus.jump_offset};
        end else if (bus.branch_en) begin
            next_pc = seq_pc + {{16{bus.branch_imm[15]}}, bus.branch_imm};
        end else begin
            next_pc = seq_pc;
        end
    end

    // All outputs are registered so nothing reaches them combinationally from inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            valid_q    <= 1'b0;
            instr_q    <= 32'd0;
            instr_pc_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    state  <= REQ;
                    req_q  <= 1'b1;
                    addr_q <= pc;
                end
                REQ: begin
                    if (bus.imem_gnt) begin
                        state <= WAIT;
                        req_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (bus.imem_rvalid) begin
                        state      <= FULL;
                        instr_q    <= bus.imem_rdata;
                        instr_pc_q <= pc;
                        valid_q    <= 1'b1;
                    end
                end
                FULL: begin
                    if (bus.instr_ready) begin
                        state   <= REQ;
                        valid_q <= 1'b0;
                        pc      <= next_pc;
                        addr_q  <= next_pc;
                        req_q   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;

endmodule
